// File: rtl/training_data_feeder.sv
// Training-sample store plus sequencer that hands one M x N sample at a time to a distance calculator.
// Optional feature macro: FEEDER_WRAP_EN (wrap to sample 0 and keep streaming instead of ending the pass).
module training_data_feeder #(
    parameter int M           = 5,
    parameter int N           = 10,
    parameter int W           = 32,
    parameter int TYPE_W      = 2,
    parameter int NUM_SAMPLES = 8,
    localparam int E  = M * N,
    localparam int SW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
    localparam int EW = (E > 1) ? $clog2(E) : 1,
    localparam int AW = (NUM_SAMPLES * E > 1) ? $clog2(NUM_SAMPLES * E) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              data_request,
    input  logic              wr_en,
    input  logic [SW-1:0]     wr_sample,
    input  logic [EW-1:0]     wr_elem,
    input  logic [W-1:0]      wr_data,
    input  logic [TYPE_W-1:0] wr_type,
    output logic [W*E-1:0]    training_data,
    output logic [TYPE_W-1:0] training_data_type,
    output logic              ready,
    output logic [SW-1:0]     sample_index,
    output logic              busy,
    output logic              all_done
);

    typedef enum logic [2:0] {IDLE, FETCH, PRESENT, WAIT_REQ, FINISH} state_t;

    state_t            state_reg, state_next;
    logic [SW-1:0]     sample_reg, sample_next;
    logic [EW-1:0]     elem_reg, elem_next;
    logic              ready_reg, ready_next;
    logic              done_reg, done_next;
    logic [TYPE_W-1:0] type_reg;

    logic [W-1:0]      mem [NUM_SAMPLES*E];
    logic [TYPE_W-1:0] label_mem [NUM_SAMPLES];
    logic [W-1:0]      rd_data_reg;
    logic [TYPE_W-1:0] rd_type_reg;
    logic [AW-1:0]     rd_addr, wr_addr;
    logic              wr_ok, copy_en;

    always_comb begin
        state_next  = state_reg;
        sample_next = sample_reg;
        elem_next   = elem_reg;
        ready_next  = 1'b0;
        done_next   = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    state_next  = FETCH;
                    sample_next = '0;
                    elem_next   = '0;
                end
                FETCH: if (elem_reg == EW'(E - 1)) begin
                    state_next = PRESENT;
                    elem_next  = '0;
                end else begin
                    elem_next = elem_reg + EW'(1);
                end
                PRESENT: begin
                    state_next = WAIT_REQ;
                    ready_next = 1'b1;
                end
                WAIT_REQ: if (data_request) begin
                    elem_next = '0;
                    if (sample_reg == SW'(NUM_SAMPLES - 1)) begin
                        done_next = 1'b1;
`ifdef FEEDER_WRAP_EN
                        sample_next = '0;
                        state_next  = FETCH;
`else
                        state_next  = FINISH;
`endif
                    end else begin
                        sample_next = sample_reg + SW'(1);
                        state_next  = FETCH;
                    end
                end
                FINISH:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // The read address follows the next-state counters so each element is
    // already in rd_data_reg during the FETCH cycle that copies it.
    assign rd_addr = AW'(sample_next) * AW'(E) + AW'(elem_next);
    assign wr_addr = AW'(wr_sample) * AW'(E) + AW'(wr_elem);
    assign wr_ok   = wr_en && (state_reg == IDLE)
                     && ({1'b0, wr_sample} < (SW+1)'(NUM_SAMPLES))
                     && ({1'b0, wr_elem} < (EW+1)'(E));
    assign copy_en = (state_reg == FETCH) && !abort;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr]         <= wr_data;
            label_mem[wr_sample] <= wr_type;
        end
        rd_data_reg <= mem[rd_addr];
        rd_type_reg <= label_mem[sample_next];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            sample_reg <= '0;
            elem_reg   <= '0;
            ready_reg  <= 1'b0;
            done_reg   <= 1'b0;
            type_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            sample_reg <= sample_next;
            elem_reg   <= elem_next;
            ready_reg  <= ready_next;
            done_reg   <= done_next;
            if (copy_en && elem_reg == '0)
                type_reg <= rd_type_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < E; gi++) begin : g_buf
            logic [W-1:0] elem_buf_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    elem_buf_reg <= '0;
                else if (copy_en && elem_reg == EW'(gi))
                    elem_buf_reg <= rd_data_reg;
            end
            assign training_data[gi*W +: W] = elem_buf_reg;
        end
    endgenerate

    assign training_data_type = type_reg;
    assign ready              = ready_reg;
    assign all_done           = done_reg;
    assign sample_index       = sample_reg;
    assign busy               = (state_reg != IDLE);

endmodule

// File: tb/tb_training_data_feeder.sv
// Scoreboard bench for training_data_feeder: stimulus queues expected samples, a negedge monitor checks them.
module tb_training_data_feeder;

    localparam int M = 2, N = 3, W = 16, TYPE_W = 2, NS = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0, abort = 1'b0, data_request = 1'b0;
    logic              wr_en = 1'b0;
    logic [1:0]        wr_sample = '0;
    logic [2:0]        wr_elem = '0;
    logic [W-1:0]      wr_data = '0;
    logic [TYPE_W-1:0] wr_type = '0;
    logic [W*M*N-1:0]  training_data;
    logic [TYPE_W-1:0] training_data_type;
    logic              ready, busy, all_done;
    logic [1:0]        sample_index;

    training_data_feeder #(.M(M), .N(N), .W(W), .TYPE_W(TYPE_W), .NUM_SAMPLES(NS)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .data_request(data_request),
        .wr_en(wr_en), .wr_sample(wr_sample), .wr_elem(wr_elem), .wr_data(wr_data), .wr_type(wr_type),
        .training_data(training_data), .training_data_type(training_data_type), .ready(ready),
        .sample_index(sample_index), .busy(busy), .all_done(all_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W*M*N-1:0]  d;
        logic [TYPE_W-1:0] t;
        logic [1:0]        i;
    } exp_t;

    exp_t sb[$];
    int   exp_done = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [W*M*N-1:0] sample_vec(input int s);
        logic [W*M*N-1:0] v;
        v = '0;
        for (int e = 0; e < M*N; e++) v[e*W +: W] = W'(10*s + e);
        return v;
    endfunction

    function automatic exp_t mk(input int s);
        exp_t x;
        x.d = sample_vec(s);
        x.t = TYPE_W'(s + 1);
        x.i = 2'(s);
        return x;
    endfunction

    // Monitor: every ready pops one expected sample, every all_done consumes one expected pulse.
    always @(negedge clk) begin
        if (ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: sample_index=%0d with nothing expected", sample_index);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("ready_data", training_data, x.d);
                chk("ready_type", training_data_type, x.t);
                chk("ready_index", sample_index, x.i);
                $display("ready: sample_index=%0d type=%0d data=%0h", sample_index, training_data_type, training_data);
            end
        end
        if (all_done) begin
            checks++;
            if (exp_done == 0) begin
                errors++;
                $display("FAIL unexpected_all_done: got 1 expected 0");
            end else begin
                exp_done--;
                $display("all_done pulse");
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int s, input int e, input int d, input int t);
        wr_en = 1'b1; wr_sample = 2'(s); wr_elem = 3'(e); wr_data = W'(d); wr_type = TYPE_W'(t);
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic do_req();
        data_request = 1'b1; step(); data_request = 1'b0;
    endtask

    // Counts edges after the launching edge until ready; pulses data_request at count 'poke'.
    task automatic wait_ready(input int poke, output int n);
        n = 0;
        while (!ready && n < 60) begin
            data_request = (n == poke);
            step();
            data_request = 1'b0;
            n++;
        end
    endtask

    initial begin
        int n;
        #3;
        chk("rst_data", training_data, 0);
        chk("rst_type", training_data_type, 0);
        chk("rst_ready", ready, 0);
        chk("rst_done", all_done, 0);
        chk("rst_index", sample_index, 0);
        chk("rst_busy", busy, 0);
        repeat (2) step();
        rst = 1'b1;
        step();

        for (int s = 0; s < NS; s++)
            for (int e = 0; e < M*N; e++)
                wr(s, e, 10*s + e, s + 1);
        wr(0, 6, 16'hDEAD, 3);
        wr(0, 7, 16'hBEEF, 3);
        wr(3, 0, 16'hCAFE, 0);

        do_req();
        step();
        chk("idle_req_busy", busy, 0);

        sb.push_back(mk(0));
        do_start();
        wait_ready(-1, n);
        chk("latency_s0", n, 7);
        repeat (2) step();
        chk("hold_data", training_data, sample_vec(0));
        chk("hold_index", sample_index, 0);
        do_start();
        step();
        chk("stray_start_index", sample_index, 0);
        chk("stray_start_busy", busy, 1);

        sb.push_back(mk(1));
        do_req();
        wait_ready(2, n);
        chk("latency_s1", n, 7);
        sb.push_back(mk(2));
        do_req();
        wait_ready(-1, n);
        chk("latency_s2", n, 7);

`ifdef FEEDER_WRAP_EN
        exp_done++;
        sb.push_back(mk(0));
        do_req();
        wait_ready(-1, n);
        chk("latency_wrap", n, 7);
        abort = 1'b1; step(); abort = 1'b0;
        chk("wrap_abort_busy", busy, 0);
`else
        exp_done++;
        do_req();
        step();
        chk("finish_busy", busy, 0);
`endif
        repeat (2) step();

        do_start();
        step(); step();
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready, 0);
        repeat (12) step();

        sb.push_back(mk(0));
        do_start();
        wait_ready(-1, n);
        chk("latency_pre_rst", n, 7);
        step();
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_data", training_data, 0);
        chk("mid_rst_type", training_data_type, 0);
        chk("mid_rst_index", sample_index, 0);
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_busy", busy, 0);
        step();
        rst = 1'b1;
        step();

        sb.push_back(mk(0));
        do_start();
        wr(0, 3, 16'h7777, 0);
        wait_ready(-1, n);
        chk("latency_post_rst", n, 6);
        abort = 1'b1; step(); abort = 1'b0;
        repeat (3) step();

        sb.push_back(mk(0));
        do_start();
        wait_ready(-1, n);
        chk("busy_write_ignored", n, 7);
        abort = 1'b1; step(); abort = 1'b0;
        repeat (3) step();

        chk("queue_empty", sb.size(), 0);
        chk("done_pending", exp_done, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
